rf68000_nic_master: RTL



---
 rtl/rf68000_nic_pkg.sv | 18 +
 rtl/rf68000_nic_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rf68000_nic_pkg.sv
// Shared definitions for the node network interface: bus-master FSM states,
// request/response field widths and the default bus-cycle timeout.
package rf68000_nic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DROP = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int ID_W  = 4;

    localparam logic [7:0] TIMEOUT_DEF = 8'd255;

endpackage

// File: rtl/rf68000_nic_master.sv
// Network-side bus initiator: turns one ring request into a single cyc/stb/ack
// cycle on the nic_* port and hands a read-data, completion or timeout response back.
module rf68000_nic_master
    import rf68000_nic_pkg::*;
#(
    parameter int             TOW     = 8,
    parameter logic [TOW-1:0] TIMEOUT = TOW'(TIMEOUT_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ID_W-1:0]   id,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_sel,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [DAT_W-1:0]  req_dat,
    input  logic [ID_W-1:0]   req_src,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DAT_W-1:0]  rsp_dat,
    output logic [ID_W-1:0]   rsp_dst,
    output logic [ID_W-1:0]   rsp_src,
    output logic              rsp_err,
    output logic              rsp_we,
    output logic              nic_cyc,
    output logic              nic_stb,
    output logic              nic_we,
    output logic [3:0]        nic_sel,
    output logic [ADR_W-1:0]  nic_adr,
    output logic [DAT_W-1:0]  nic_dato,
    input  logic [DAT_W-1:0]  nic_dati,
    input  logic              nic_ack
);

    state_t             state_q,     state_d;
    logic [TOW-1:0]     cnt_q,       cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q,   rsp_err_d;
    logic [DAT_W-1:0]   rsp_dat_q,   rsp_dat_d;
    logic [ID_W-1:0]    rsp_dst_q,   rsp_dst_d;
    logic               rsp_we_q,    rsp_we_d;
    logic               we_q,        we_d;
    logic [ID_W-1:0]    src_q,       src_d;
    logic               nic_cyc_q,   nic_cyc_d;
    logic               nic_we_q,    nic_we_d;
    logic [3:0]         nic_sel_q,   nic_sel_d;
    logic [ADR_W-1:0]   nic_adr_q,   nic_adr_d;
    logic [DAT_W-1:0]   nic_dato_q,  nic_dato_d;

    // A lingering ack from the previous cycle blocks acceptance of a new request.
    assign req_ready = req_ready_q & ~nic_ack;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_dst   = rsp_dst_q;
    assign rsp_src   = id;
    assign rsp_we    = rsp_we_q;
    assign nic_cyc   = nic_cyc_q;
    assign nic_stb   = nic_cyc_q;
    assign nic_we    = nic_we_q;
    assign nic_sel   = nic_sel_q;
    assign nic_adr   = nic_adr_q;
    assign nic_dato  = nic_dato_q;

    // Next-state and next-output computation for the single-cycle bus master.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_dst_d   = rsp_dst_q;
        rsp_we_d    = rsp_we_q;
        we_d        = we_q;
        src_d       = src_q;
        nic_cyc_d   = nic_cyc_q;
        nic_we_d    = nic_we_q;
        nic_sel_d   = nic_sel_q;
        nic_adr_d   = nic_adr_q;
        nic_dato_d  = nic_dato_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && !nic_ack) begin
                    we_d        = req_we;
                    src_d       = req_src;
                    nic_cyc_d   = 1'b1;
                    nic_we_d    = req_we;
                    nic_sel_d   = req_sel;
                    nic_adr_d   = req_adr;
                    nic_dato_d  = req_dat;
                    cnt_d       = {TOW{1'b0}};
                    req_ready_d = 1'b0;
                    state_d     = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + {{(TOW-1){1'b0}}, 1'b1};
                // Ack is tested first so it beats a timeout landing on the same cycle.
                if (nic_ack) begin
                    rsp_dat_d = we_q ? {DAT_W{1'b0}} : nic_dati;
                    rsp_err_d = 1'b0;
                    rsp_dst_d = src_q;
                    rsp_we_d  = we_q;
                    nic_cyc_d = 1'b0;
                    nic_we_d  = 1'b0;
                    nic_sel_d = 4'b0000;
                    state_d   = ST_DROP;
                end else if (cnt_q == (TIMEOUT - {{(TOW-1){1'b0}}, 1'b1})) begin
                    rsp_dat_d = {DAT_W{1'b0}};
                    rsp_err_d = 1'b1;
                    rsp_dst_d = src_q;
                    rsp_we_d  = we_q;
                    nic_cyc_d = 1'b0;
                    nic_we_d  = 1'b0;
                    nic_sel_d = 4'b0000;
                    state_d   = ST_DROP;
                end else begin
                    state_d = ST_BUS;
                end
            end

            ST_DROP: begin
                if (!nic_ack) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end

            default: begin
                nic_cyc_d   = 1'b0;
                nic_we_d    = 1'b0;
                nic_sel_d   = 4'b0000;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus and discards any pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {TOW{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= {DAT_W{1'b0}};
            rsp_dst_q   <= {ID_W{1'b0}};
            rsp_we_q    <= 1'b0;
            we_q        <= 1'b0;
            src_q       <= {ID_W{1'b0}};
            nic_cyc_q   <= 1'b0;
            nic_we_q    <= 1'b0;
            nic_sel_q   <= 4'b0000;
            nic_adr_q   <= {ADR_W{1'b0}};
            nic_dato_q  <= {DAT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_dst_q   <= rsp_dst_d;
            rsp_we_q    <= rsp_we_d;
            we_q        <= we_d;
            src_q       <= src_d;
            nic_cyc_q   <= nic_cyc_d;
            nic_we_q    <= nic_we_d;
            nic_sel_q   <= nic_sel_d;
            nic_adr_q   <= nic_adr_d;
            nic_dato_q  <= nic_dato_d;
        end
    end

endmodule
